// File: rtl/mcu_alu_core_if.sv
// ============================================================================
//  mcu_alu_core_if : operand/result bundle between the datapath and the ALU
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface mcu_alu_core_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] Operand1;
   logic [WIDTH-1:0] Operand2;
   logic [3:0]       Mode;
   logic             E;
   logic [WIDTH-1:0] Out;
   logic [3:0]       CFlags;
   logic             Flags;

   modport master (
      output Operand1, Operand2, Mode, E,
      input  Out, CFlags, Flags
   );

   modport slave (
      input  Operand1, Operand2, Mode, E,
      output Out, CFlags, Flags
   );
endinterface

`default_nettype wire

// File: rtl/mcu_alu_core.sv
// ============================================================================
//  mcu_alu_core : registered 16-op ALU with {Z,C,S,O} condition flags
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mcu_alu_core #(
   parameter int WIDTH = 8
) (
   input wire            clk,
   input wire            rst_n,
   mcu_alu_core_if.slave bus
);
   localparam logic [3:0] C_ADD  = 4'b0000;
   localparam logic [3:0] C_SUB  = 4'b0001;
   localparam logic [3:0] C_MOVA = 4'b0010;
   localparam logic [3:0] C_MOVB = 4'b0011;
   localparam logic [3:0] C_AND  = 4'b0100;
   localparam logic [3:0] C_OR   = 4'b0101;
   localparam logic [3:0] C_XOR  = 4'b0110;
   localparam logic [3:0] C_RSUB = 4'b0111;
   localparam logic [3:0] C_INC  = 4'b1000;
   localparam logic [3:0] C_DEC  = 4'b1001;
   localparam logic [3:0] C_ROL  = 4'b1010;
   localparam logic [3:0] C_ROR  = 4'b1011;
   localparam logic [3:0] C_SHL  = 4'b1100;
   localparam logic [3:0] C_SHR  = 4'b1101;
   localparam logic [3:0] C_NOT  = 4'b1110;
   localparam logic [3:0] C_NEG  = 4'b1111;
   localparam int         C_MSB  = WIDTH - 1;

   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [2:0]       w_n;
   logic [WIDTH:0]   w_ext;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_o;

   logic [WIDTH-1:0] r_out;
   logic [3:0]       r_cflags;
   logic             r_flags;

   assign w_a = bus.Operand1;
   assign w_b = bus.Operand2;
   assign w_n = bus.Operand2[2:0];

   // Arithmetic ops run one bit wider so the top bit of w_ext is carry/borrow.
   always_comb begin
      w_ext = '0;
      w_res = '0;
      w_c   = 1'b0;
      w_o   = 1'b0;
      case (bus.Mode)
         C_ADD: begin
            w_ext = {1'b0, w_a} + {1'b0, w_b};
            w_res = w_ext[C_MSB:0];
            w_c   = w_ext[WIDTH];
            w_o   = (w_a[C_MSB] == w_b[C_MSB]) && (w_res[C_MSB] != w_a[C_MSB]);
         end
         C_SUB: begin
            w_ext = {1'b0, w_a} - {1'b0, w_b};
            w_res = w_ext[C_MSB:0];
            w_c   = w_ext[WIDTH];
            w_o   = (w_a[C_MSB] != w_b[C_MSB]) && (w_res[C_MSB] != w_a[C_MSB]);
         end
         C_RSUB: begin
            w_ext = {1'b0, w_b} - {1'b0, w_a};
            w_res = w_ext[C_MSB:0];
            w_c   = w_ext[WIDTH];
            w_o   = (w_a[C_MSB] != w_b[C_MSB]) && (w_res[C_MSB] != w_b[C_MSB]);
         end
         C_INC: begin
            w_ext = {1'b0, w_a} + {{WIDTH{1'b0}}, 1'b1};
            w_res = w_ext[C_MSB:0];
            w_c   = w_ext[WIDTH];
            w_o   = !w_a[C_MSB] && w_res[C_MSB];
         end
         C_DEC: begin
            w_ext = {1'b0, w_a} - {{WIDTH{1'b0}}, 1'b1};
            w_res = w_ext[C_MSB:0];
            w_c   = w_ext[WIDTH];
            w_o   = w_a[C_MSB] && !w_res[C_MSB];
         end
         C_NEG: begin
            w_ext = {(WIDTH+1){1'b0}} - {1'b0, w_a};
            w_res = w_ext[C_MSB:0];
            w_c   = w_ext[WIDTH];
            w_o   = w_a[C_MSB] && w_res[C_MSB];
         end
         C_MOVA: w_res = w_a;
         C_MOVB: w_res = w_b;
         C_AND:  w_res = w_a & w_b;
         C_OR:   w_res = w_a | w_b;
         C_XOR:  w_res = w_a ^ w_b;
         // A shift by WIDTH yields zero, so n=0 leaves A unchanged.
         C_ROL:  w_res = (w_a << w_n) | (w_a >> (WIDTH - int'(w_n)));
         C_ROR:  w_res = (w_a >> w_n) | (w_a << (WIDTH - int'(w_n)));
         C_SHL:  w_res = w_a << w_n;
         C_SHR:  w_res = w_a >> w_n;
         C_NOT:  w_res = ~w_a;
         default: w_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out    <= '0;
         r_cflags <= 4'b0000;
         r_flags  <= 1'b0;
      end else begin
         r_flags <= bus.E;
         if (bus.E) begin
            r_out    <= w_res;
            r_cflags <= {(w_res == '0), w_c, w_res[C_MSB], w_o};
         end
      end
   end

   assign bus.Out    = r_out;
   assign bus.CFlags = r_cflags;
   assign bus.Flags  = r_flags;
endmodule

`default_nettype wire

// File: tb/tb_mcu_alu_core.sv
// ============================================================================
//  tb_mcu_alu_core : directed vectors plus a cycle-by-cycle integer ALU model
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mcu_alu_core;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   bit   check_en = 1'b0;

   logic [7:0] m_out;
   logic [3:0] m_cf;
   logic       m_flags;

   mcu_alu_core_if #(.WIDTH(8)) bus ();

   mcu_alu_core #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sgn(input int v);
      return (v > 127) ? v - 256 : v;
   endfunction

   // Reference ALU in plain integer arithmetic.
   function automatic void model(input int mode, input int a, input int b,
                                 output logic [7:0] r, output logic [3:0] cf);
      int res, sres, n;
      bit c, o;
      n = b & 7;
      c = 1'b0;
      o = 1'b0;
      sres = 0;
      case (mode)
         0:  begin res = a + b; c = (res > 255); sres = sgn(a) + sgn(b); o = 1'b1; end
         1:  begin res = a - b; c = (a < b);     sres = sgn(a) - sgn(b); o = 1'b1; end
         2:  res = a;
         3:  res = b;
         4:  res = a & b;
         5:  res = a | b;
         6:  res = a ^ b;
         7:  begin res = b - a; c = (b < a);     sres = sgn(b) - sgn(a); o = 1'b1; end
         8:  begin res = a + 1; c = (res > 255); sres = sgn(a) + 1;      o = 1'b1; end
         9:  begin res = a - 1; c = (a < 1);     sres = sgn(a) - 1;      o = 1'b1; end
         10: begin res = a; for (int i = 0; i < n; i++) res = ((res << 1) | (res >> 7)) & 255; end
         11: begin res = a; for (int i = 0; i < n; i++) res = (res >> 1) | ((res & 1) << 7); end
         12: res = (a << n) & 255;
         13: res = a >> n;
         14: res = 255 - a;
         default: begin res = 0 - a; c = (a != 0); sres = 0 - sgn(a); o = 1'b1; end
      endcase
      if (o) o = (sres > 127) || (sres < -128);
      r  = res[7:0];
      cf = {(r == 8'd0), c, r[7], o};
   endfunction

   // Model state advances on the same edge the DUT registers.
   initial forever begin
      logic [7:0] r;
      logic [3:0] cf;
      @(posedge clk);
      if (!rst_n) begin
         m_out = 8'd0; m_cf = 4'd0; m_flags = 1'b0;
      end else begin
         m_flags = bus.E;
         if (bus.E) begin
            model(int'(bus.Mode), int'(bus.Operand1), int'(bus.Operand2), r, cf);
            m_out = r;
            m_cf  = cf;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (check_en) begin
         chk("cyc_out", 32'(bus.Out), 32'(m_out));
         chk("cyc_cflags", 32'(bus.CFlags), 32'(m_cf));
         chk("cyc_flags", 32'(bus.Flags), 32'(m_flags));
      end
   end

   task automatic op(input string name, input logic [3:0] mode, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] eo, input logic [3:0] ecf);
      @(negedge clk);
      bus.Mode = mode; bus.Operand1 = a; bus.Operand2 = b; bus.E = 1'b1;
      @(posedge clk);
      #1;
      chk({name, "_out"}, 32'(bus.Out), 32'(eo));
      chk({name, "_cf"}, 32'(bus.CFlags), 32'(ecf));
      chk({name, "_strobe"}, 32'(bus.Flags), 32'd1);
      chk({name, "_model"}, 32'({m_out, m_cf}), 32'({eo, ecf}));
   endtask

   initial begin
      bus.Mode = 4'b0000; bus.Operand1 = 8'd12; bus.Operand2 = 8'd5; bus.E = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", 32'(bus.Out), 32'd0);
      chk("rst_cflags", 32'(bus.CFlags), 32'd0);
      chk("rst_flags", 32'(bus.Flags), 32'd0);
      check_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      op("add",      4'b0000, 8'd12,  8'd5,   8'd17,  4'b0000);
      op("sub",      4'b0001, 8'd12,  8'd5,   8'd7,   4'b0000);
      op("mova",     4'b0010, 8'd12,  8'd5,   8'd12,  4'b0000);
      op("add_c",    4'b0000, 8'd200, 8'd100, 8'd44,  4'b0100);
      op("add_o",    4'b0000, 8'd100, 8'd100, 8'd200, 4'b0011);
      op("sub_b",    4'b0001, 8'd5,   8'd12,  8'd249, 4'b0110);
      op("sub_z",    4'b0001, 8'd12,  8'd12,  8'd0,   4'b1000);
      op("sub_o",    4'b0001, 8'h80,  8'h01,  8'h7F,  4'b0001);
      op("rsub",     4'b0111, 8'd12,  8'd5,   8'd249, 4'b0110);
      op("movb",     4'b0011, 8'd7,   8'd0,   8'd0,   4'b1000);
      op("and",      4'b0100, 8'hF0,  8'h3C,  8'h30,  4'b0000);
      op("or",       4'b0101, 8'hF0,  8'h0F,  8'hFF,  4'b0010);
      op("xor",      4'b0110, 8'hAA,  8'hAA,  8'h00,  4'b1000);
      op("inc_wrap", 4'b1000, 8'hFF,  8'h00,  8'h00,  4'b1100);
      op("inc_o",    4'b1000, 8'h7F,  8'h00,  8'h80,  4'b0011);
      op("dec_wrap", 4'b1001, 8'h00,  8'h00,  8'hFF,  4'b0110);
      op("rol",      4'b1010, 8'd12,  8'd5,   8'd129, 4'b0010);
      op("rol_n0",   4'b1010, 8'h5A,  8'h08,  8'h5A,  4'b0000);
      op("ror",      4'b1011, 8'h81,  8'h01,  8'hC0,  4'b0010);
      op("shl",      4'b1100, 8'h81,  8'h01,  8'h02,  4'b0000);
      op("shr",      4'b1101, 8'h80,  8'h07,  8'h01,  4'b0000);
      op("not",      4'b1110, 8'h0F,  8'h00,  8'hF0,  4'b0010);
      op("neg_80",   4'b1111, 8'h80,  8'h00,  8'h80,  4'b0111);
      op("neg_0",    4'b1111, 8'h00,  8'h00,  8'h00,  4'b1000);

      // Hold: E low with new inputs must leave Out/CFlags untouched.
      op("pre_hold", 4'b0000, 8'd12,  8'd5,   8'd17,  4'b0000);
      @(negedge clk);
      bus.E = 1'b0; bus.Mode = 4'b0001; bus.Operand1 = 8'd1; bus.Operand2 = 8'd2;
      @(posedge clk);
      #1;
      chk("hold_out", 32'(bus.Out), 32'd17);
      chk("hold_cflags", 32'(bus.CFlags), 32'd0);
      chk("hold_flags", 32'(bus.Flags), 32'd0);

      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         bus.Mode     = 4'($urandom_range(0, 15));
         bus.Operand1 = 8'($urandom_range(0, 255));
         bus.Operand2 = 8'($urandom_range(0, 255));
         bus.E        = ($urandom_range(0, 3) != 0);
      end

      // Reset asserted mid-stream with E high.
      @(negedge clk);
      rst_n = 1'b0; bus.E = 1'b1;
      @(posedge clk);
      #1;
      chk("rst2_out", 32'(bus.Out), 32'd0);
      chk("rst2_flags", 32'(bus.Flags), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
